// File: rtl/score_disp_ctrl.sv
// Score display controller: converts the binary game score to packed BCD with a
// sequential double-dabble engine and scans it onto an 8-digit seven-segment display.
module score_disp_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] score,
    input  logic        blank_en,
    output logic [31:0] bcd,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [31:0]      BIN_MAX  = 32'd99999999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cap_q, cap_d;
    logic        ovf_q, ovf_d;
    logic [31:0] bin_sr_q, bin_sr_d;
    logic [31:0] bcd_sr_q, bcd_sr_d;
    logic [4:0]  iter_q, iter_d;
    logic [31:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       an_q, seg_q;

    // Add-3 correction applied to every BCD nibble before the shift.
    logic [31:0] bcd_adj;
    always_comb begin
        bcd_adj = bcd_sr_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        ovf_d    = ovf_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        iter_d   = iter_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (score != cap_q) begin
                    cap_d    = score;
                    ovf_d    = (score > BIN_MAX);
                    bin_sr_d = (score > BIN_MAX) ? BIN_MAX : score;
                    bcd_sr_d = 32'd0;
                    iter_d   = 5'd0;
                    busy_d   = 1'b1;
                    state_d  = CONV;
                end
            end
            CONV: begin
                bcd_sr_d = {bcd_adj[30:0], bin_sr_q[31]};
                bin_sr_d = {bin_sr_q[30:0], 1'b0};
                iter_d   = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = bcd_sr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cap_q    <= 32'd0;
            ovf_q    <= 1'b0;
            bin_sr_q <= 32'd0;
            bcd_sr_q <= 32'd0;
            iter_q   <= 5'd0;
            bcd_q    <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            ovf_q    <= ovf_d;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            iter_q   <= iter_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    function automatic logic [6:0] seg7_enc(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7_enc = 7'h40;
            4'd1:    seg7_enc = 7'h79;
            4'd2:    seg7_enc = 7'h24;
            4'd3:    seg7_enc = 7'h30;
            4'd4:    seg7_enc = 7'h19;
            4'd5:    seg7_enc = 7'h12;
            4'd6:    seg7_enc = 7'h02;
            4'd7:    seg7_enc = 7'h78;
            4'd8:    seg7_enc = 7'h00;
            4'd9:    seg7_enc = 7'h10;
            default: seg7_enc = 7'h7F;
        endcase
    endfunction

    // upper_zero[i] is set when digits i..7 of the display buffer are all zero.
    logic [7:0] upper_zero;
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            run           = run & (bcd_q[4*i +: 4] == 4'd0);
            upper_zero[i] = run;
        end
    end

    logic       blanked;
    logic [7:0] an_next, seg_next;
    always_comb begin
        blanked  = blank_en && (idx_q != 3'd0) && upper_zero[idx_q];
        an_next  = blanked ? 8'hFF : ~(8'd1 << idx_q);
        seg_next = {~((idx_q == 3'd0) && ovf_q), seg7_enc(bcd_q[4*idx_q +: 4])};
    end

    // The digit pointed to at the wrap edge is latched onto the pins, then the pointer advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= 3'd0;
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 3'd1;
            an_q  <= an_next;
            seg_q <= seg_next;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_score_disp_ctrl.sv
// Self-checking bench for score_disp_ctrl: scoreboarded conversions plus display-scan checks.
module tb_score_disp_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] score = 32'd0;
    logic        blank_en = 1'b0;
    logic [31:0] bcd;
    logic        busy, done, ovf;
    logic [7:0]  an, seg;

    score_disp_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .blank_en (blank_en),
        .bcd      (bcd),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    logic [7:0] an_f[8];
    logic [7:0] seg_f[8];

    // Scoreboard: every done pulse pops and compares the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done === 1'b1) begin
                done_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: bcd=%h ovf=%b with no expected entry", bcd, ovf);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bcd !== mon_e.bcd || ovf !== mon_e.ovf) begin
                        errors++;
                        $display("FAIL sb_result: bcd=%h ovf=%b expected bcd=%h ovf=%b",
                                 bcd, ovf, mon_e.bcd, mon_e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic push_exp(input logic [31:0] b, input logic o);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: done_cnt=%0d expected>=%0d", name, done_cnt, target);
        end
    endtask

    // Aligns to the slot where digit 0 is freshly lit, then samples all eight scan slots.
    task automatic capture_frame(input string name);
        logic [7:0] prev;
        int         n;
        bit         found;
        prev  = an;
        found = 0;
        n     = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (an === 8'hFE && prev !== 8'hFE) found = 1;
            else prev = an;
            n++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_frame_sync: an=%h never stepped to FE", name, an);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (SCAN_DIV) @(negedge clk);
            an_f[k]  = an;
            seg_f[k] = seg;
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_an;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 8'hFF || seg !== 8'hFF || bcd !== 32'd0 || busy !== 1'b0 ||
            done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: an=%h seg=%h bcd=%h busy=%b done=%b ovf=%b expected FF FF 0 0 0 0",
                     an, seg, bcd, busy, done, ovf);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL scan_before_wrap: an=%h expected FF", an);
        end
        @(negedge clk);
        checks++;
        if (an !== 8'hFE || seg !== 8'hC0) begin
            errors++;
            $display("FAIL scan_first_wrap: an=%h seg=%h expected FE C0", an, seg);
        end
        for (int k = 1; k < 9; k++) begin
            repeat (SCAN_DIV) @(negedge clk);
            exp_an = ~(8'd1 << (k % 8));
            checks++;
            if (an !== exp_an || seg !== 8'hC0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL scan_step%0d: an=%h seg=%h busy=%b expected %h C0 0", k, an, seg, busy, exp_an);
            end
        end
    endtask

    task automatic test_conversion;
        @(negedge clk);
        push_exp(32'h12345678, 1'b0);
        score = 32'h00BC614E;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL conv_busy_cycle%0d: busy=%b done=%b expected 1 0", i, busy, done);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || bcd !== 32'h12345678) begin
            errors++;
            $display("FAIL conv_latency: busy=%b done=%b bcd=%h expected 0 1 12345678", busy, done, bcd);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL conv_done_width: done=%b expected 0", done);
        end
        capture_frame("conv");
        checks++;
        if (an_f[0] !== 8'hFE || seg_f[0] !== 8'h80 || seg_f[1] !== 8'hF8 ||
            an_f[7] !== 8'h7F || seg_f[7] !== 8'hF9) begin
            errors++;
            $display("FAIL conv_display: d0=%h/%h d1=%h d7=%h/%h expected FE/80 F8 7F/F9",
                     an_f[0], seg_f[0], seg_f[1], an_f[7], seg_f[7]);
        end
    endtask

    task automatic test_overflow;
        int t;
        @(negedge clk);
        push_exp(32'h99999999, 1'b1);
        t = done_cnt + 1;
        score = 32'd100000000;
        wait_done(t, "ovf");
        checks++;
        if (ovf !== 1'b1 || bcd !== 32'h99999999) begin
            errors++;
            $display("FAIL ovf_result: ovf=%b bcd=%h expected 1 99999999", ovf, bcd);
        end
        capture_frame("ovf");
        checks++;
        if (an_f[0] !== 8'hFE || seg_f[0] !== 8'h10 || seg_f[7] !== 8'h90) begin
            errors++;
            $display("FAIL ovf_display: d0=%h/%h d7=%h expected FE/10 90", an_f[0], seg_f[0], seg_f[7]);
        end
        push_exp(32'h00000007, 1'b0);
        t = done_cnt + 1;
        score = 32'd7;
        wait_done(t, "ovf_clear");
        checks++;
        if (ovf !== 1'b0 || bcd !== 32'h7) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b bcd=%h expected 0 00000007", ovf, bcd);
        end
        capture_frame("ovf_clear");
        checks++;
        if (seg_f[0] !== 8'hF8) begin
            errors++;
            $display("FAIL ovf_dp_clear: d0 seg=%h expected F8", seg_f[0]);
        end
    endtask

    task automatic test_back_to_back;
        int t;
        @(negedge clk);
        push_exp(32'h00000005, 1'b0);
        t = done_cnt;
        score = 32'd5;
        repeat (11) @(negedge clk);
        push_exp(32'h00000042, 1'b0);
        score = 32'd42;
        wait_done(t + 2, "b2b");
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt !== t + 2 || bcd !== 32'h42 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulses: done pulses=%0d bcd=%h busy=%b expected 2 00000042 0",
                     done_cnt - t, bcd, busy);
        end
    endtask

    task automatic test_reset_abort;
        int t;
        @(negedge clk);
        score = 32'd999;
        repeat (11) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bcd !== 32'h42) begin
            errors++;
            $display("FAIL abort_pre: busy=%b bcd=%h expected 1 00000042", busy, bcd);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bcd !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 ||
            an !== 8'hFF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL abort_async: bcd=%h busy=%b done=%b ovf=%b an=%h seg=%h expected 0 0 0 0 FF FF",
                     bcd, busy, done, ovf, an, seg);
        end
        repeat (2) @(negedge clk);
        push_exp(32'h00000999, 1'b0);
        t = done_cnt + 1;
        rst = 1'b0;
        repeat (33) @(negedge clk);
        checks++;
        if (done !== 1'b0 || bcd !== 32'd0) begin
            errors++;
            $display("FAIL abort_restart_early: done=%b bcd=%h expected 0 00000000", done, bcd);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || bcd !== 32'h999) begin
            errors++;
            $display("FAIL abort_restart: done=%b bcd=%h expected 1 00000999", done, bcd);
        end
        wait_done(t, "abort");
    endtask

    task automatic test_blanking;
        int t;
        @(negedge clk);
        blank_en = 1'b1;
        push_exp(32'h00000042, 1'b0);
        t = done_cnt + 1;
        score = 32'd42;
        wait_done(t, "blank42");
        capture_frame("blank42");
        checks++;
        if (an_f[0] !== 8'hFE || seg_f[0] !== 8'hA4 || an_f[1] !== 8'hFD || seg_f[1] !== 8'h99) begin
            errors++;
            $display("FAIL blank42_lit: d0=%h/%h d1=%h/%h expected FE/A4 FD/99",
                     an_f[0], seg_f[0], an_f[1], seg_f[1]);
        end
        for (int k = 2; k < 8; k++) begin
            checks++;
            if (an_f[k] !== 8'hFF) begin
                errors++;
                $display("FAIL blank42_d%0d: an=%h expected FF", k, an_f[k]);
            end
        end
        push_exp(32'h00000000, 1'b0);
        t = done_cnt + 1;
        score = 32'd0;
        wait_done(t, "blank0");
        capture_frame("blank0");
        checks++;
        if (an_f[0] !== 8'hFE || seg_f[0] !== 8'hC0) begin
            errors++;
            $display("FAIL blank0_d0: an=%h seg=%h expected FE C0", an_f[0], seg_f[0]);
        end
        for (int k = 1; k < 8; k++) begin
            checks++;
            if (an_f[k] !== 8'hFF) begin
                errors++;
                $display("FAIL blank0_d%0d: an=%h expected FF", k, an_f[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_blanking();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected results never produced", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
